// File: rtl/cdb_arbiter_if.sv
// CDB packet type and the producer/arbiter bus interface.
// master = producer side, slave = arbiter side.
package cdb_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic [7:0]  rob_tag;
        logic [31:0] value;
    } ex_wr_packet_t;
endpackage

interface cdb_arbiter_if #(parameter int unsigned N_REQ = 3);
    cdb_arbiter_pkg::ex_wr_packet_t [N_REQ-1:0] fu_packet;
    logic [N_REQ-1:0]                           fu_ready;
    logic [N_REQ-1:0]                           grant;
    cdb_arbiter_pkg::ex_wr_packet_t             cdb_packet;

    modport master (output fu_packet, input fu_ready, input grant, input cdb_packet);
    modport slave  (input fu_packet, output fu_ready, output grant, output cdb_packet);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a one-entry holding register per producer.
// Outputs depend only on registered state, except fu_ready which also sees flush.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          hold_valid;
    ex_wr_packet_t [N_REQ-1:0] hold_pkt;
    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             next_ptr;
    logic [N_REQ-1:0]          grant;
    logic [PW-1:0]             grant_idx;
    logic                      found;
    logic [N_REQ-1:0]          ready;
    ex_wr_packet_t             cdb;

    // First valid holder at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!found && hold_valid[PW'(idx)]) begin
                found               = 1'b1;
                grant_idx           = PW'(idx);
                grant[PW'(idx)]     = 1'b1;
            end
        end
    end

    always_comb begin
        next_ptr = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
        ready    = {N_REQ{~flush}} & (~hold_valid | grant);
        cdb      = '0;
        if (found) begin
            cdb       = hold_pkt[grant_idx];
            cdb.valid = 1'b1;
        end
    end

    assign bus.grant      = grant;
    assign bus.fu_ready   = ready;
    assign bus.cdb_packet = cdb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= '0;
            hold_pkt   <= '0;
            rr_ptr     <= '0;
        end else begin
            if (found) begin
                rr_ptr <= next_ptr;
            end
            // Capture wins over drain so a granted slot can refill in the same cycle.
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (bus.fu_packet[i].valid && ready[i]) begin
                    hold_pkt[i]   <= bus.fu_packet[i];
                    hold_valid[i] <= 1'b1;
                end else if (grant[i] || flush) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected CDB results into a queue,
// a negedge monitor pops and compares each granted (non-flushed) result.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct {
        logic [2:0]  grant;
        logic [7:0]  tag;
        logic [31:0] value;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned na = 0;
    int unsigned nb = 0;
    exp_t exp_q[$];
    exp_t e;

    cdb_arbiter_if #(.N_REQ(3)) bus ();

    cdb_arbiter #(.N_REQ(3)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] val_of(input int unsigned i, input logic [7:0] tag);
        return {16'hC0DE, 4'(i), 4'h0, tag};
    endfunction

    task automatic issue(input int unsigned i, input logic [7:0] tag, input bit push);
        exp_t x;
        bus.fu_packet[i] = '{valid: 1'b1, rob_tag: tag, value: val_of(i, tag)};
        if (push) begin
            x.grant = 3'(1 << i);
            x.tag   = tag;
            x.value = val_of(i, tag);
            exp_q.push_back(x);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0;
        bus.fu_packet = '0;
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    // Scoreboard monitor plus per-cycle protocol assertions.
    always @(negedge clock) begin
        if (reset) begin
            checks++;
            assert ($onehot0(bus.grant) && (bus.cdb_packet.valid == |bus.grant)
                    && ((bus.grant & ~dut.hold_valid) == 3'b000))
            else begin
                errors++;
                $display("FAIL grant_assert: got grant=%b valid=%b expected onehot0 grant matching valid",
                         bus.grant, bus.cdb_packet.valid);
            end
            if (!flush) begin
                checks++;
                assert ((bus.fu_packet[0].valid && !bus.fu_ready[0]) == 1'b0
                        && (bus.fu_packet[1].valid && !bus.fu_ready[1]) == 1'b0
                        && (bus.fu_packet[2].valid && !bus.fu_ready[2]) == 1'b0)
                else begin
                    errors++;
                    $display("FAIL protocol: got valid while not ready, ready=%b expected no request", bus.fu_ready);
                end
            end
            if (|bus.grant && !flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL cdb_unexpected: got grant=%b tag=%h expected no result",
                             bus.grant, bus.cdb_packet.rob_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.grant !== e.grant || bus.cdb_packet.rob_tag !== e.tag
                        || bus.cdb_packet.value !== e.value) begin
                        errors++;
                        $display("FAIL cdb_result: got grant=%b tag=%h value=%h expected grant=%b tag=%h value=%h",
                                 bus.grant, bus.cdb_packet.rob_tag, bus.cdb_packet.value,
                                 e.grant, e.tag, e.value);
                    end
                end
            end
        end
    end

    initial begin
        bus.fu_packet = '0;

        // 1: reset and idle
        @(negedge clock);
        check("rst_cdb", bus.cdb_packet, '0);
        check("rst_grant", bus.grant, 3'b000);
        check("rst_ready", bus.fu_ready, 3'b111);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mid();
            check("idle_cdb", bus.cdb_packet, '0);
            check("idle_grant", bus.grant, 3'b000);
            check("idle_ready", bus.fu_ready, 3'b111);
            step();
        end

        // 2: single request, one-cycle latency
        do_reset();
        issue(0, 8'd5, 1);
        bus.fu_packet[0].value = 32'h10;
        exp_q[exp_q.size()-1].value = 32'h10;
        step();
        bus.fu_packet = '0;
        mid();
        check("t2_grant_c1", bus.grant, 3'b001);
        step();
        mid();
        check("t2_grant_c2", bus.grant, 3'b000);
        check("t2_cdb_c2", bus.cdb_packet, '0);
        step();

        // 3: all three at once, then pointer position probe
        do_reset();
        issue(0, 8'd1, 1);
        issue(1, 8'd2, 1);
        issue(2, 8'd3, 1);
        step();
        bus.fu_packet = '0;
        mid();
        check("t3_grant_c1", bus.grant, 3'b001);
        check("t3_ready2_c1", bus.fu_ready[2], 1'b0);
        step();
        mid();
        check("t3_grant_c2", bus.grant, 3'b010);
        check("t3_ready2_c2", bus.fu_ready[2], 1'b0);
        step();
        mid();
        check("t3_grant_c3", bus.grant, 3'b100);
        check("t3_ready2_c3", bus.fu_ready[2], 1'b1);
        step();
        issue(0, 8'd7, 1);
        issue(2, 8'd8, 1);
        mid();
        check("t3_no_comb_path", bus.grant, 3'b000);
        step();
        bus.fu_packet = '0;
        mid();
        check("t3_ptr_wrapped", bus.grant, 3'b001);
        step();
        step();

        // 4: producers 0 and 2 streaming
        do_reset();
        na = 0;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            bus.fu_packet = '0;
            if (bus.fu_ready[0] && na < 8) begin
                issue(0, 8'(32'h10 + na), 1);
                na++;
            end
            if (bus.fu_ready[2] && nb < 8) begin
                issue(2, 8'(32'h20 + nb), 1);
                nb++;
            end
            mid();
            if (c >= 1 && c <= 15) begin
                check("t4_ready0", bus.fu_ready[0], 64'(c % 2 == 1));
                check("t4_ready2", bus.fu_ready[2], 64'(c % 2 == 0));
            end
            step();
        end
        bus.fu_packet = '0;
        check("t4_issued", {32'(na), 32'(nb)}, {32'd8, 32'd8});

        // 5: flush with all three held
        do_reset();
        issue(0, 8'h31, 0);
        issue(1, 8'h32, 0);
        issue(2, 8'h33, 0);
        step();
        bus.fu_packet = '0;
        flush = 1'b1;
        issue(1, 8'h3F, 0);
        mid();
        check("t5_ready_flush", bus.fu_ready, 3'b000);
        check("t5_grant_flush", bus.grant, 3'b001);
        check("t5_tag_flush", bus.cdb_packet.rob_tag, 8'h31);
        step();
        flush = 1'b0;
        bus.fu_packet = '0;
        issue(1, 8'h41, 1);
        issue(0, 8'h40, 1);
        mid();
        check("t5_grant_after", bus.grant, 3'b000);
        check("t5_cdb_after", bus.cdb_packet, '0);
        step();
        bus.fu_packet = '0;
        mid();
        check("t5_ptr_moved", bus.grant, 3'b010);
        step();
        step();

        // 6: asynchronous reset with entries held
        do_reset();
        issue(1, 8'h51, 1);
        issue(2, 8'h52, 0);
        step();
        bus.fu_packet = '0;
        mid();
        #2 reset = 1'b0;
        #1;
        check("t6_grant_async", bus.grant, 3'b000);
        check("t6_cdb_async", bus.cdb_packet, '0);
        check("t6_ready_async", bus.fu_ready, 3'b111);
        @(posedge clock);
        #1 reset = 1'b1;
        issue(0, 8'h60, 1);
        issue(2, 8'h61, 1);
        step();
        bus.fu_packet = '0;
        mid();
        check("t6_grant_post", bus.grant, 3'b001);
        step();
        step();
        step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
